// File: rtl/db_reader.sv
// ---------------------------------------------------------------------------
// db_reader
//   Reads a burst of words from an asynchronous two-port data bank and
//   presents them two at a time on a valid/ready output stream. Lane A
//   carries the word at ptr and lane B the word at ptr+1. The address wraps
//   from DEPTH-1 back to 0.
//
// Handshake: a beat transfers on a rising clk edge where out_valid_o and
//   out_ready_i are both high. Once out_valid_o is raised, every out_* signal
//   holds steady until that transfer. out_valid_o never depends
//   combinationally on out_ready_i.
//
// Ports
//   clk_i          single clock, all state changes on posedge
//   rst_i          synchronous active-high reset
//   start_i        one-cycle burst request, sampled only in IDLE
//   base_addr_i    first bank address of the burst
//   len_i          number of words to read (clipped to DEPTH)
//   busy_o         high whenever the block is not in IDLE
//   done_o         one-cycle pulse at burst completion
//   err_o          one-cycle pulse with done_o when base_addr_i >= DEPTH
//   raddr_a_o      bank read address, lane A
//   raddr_b_o      bank read address, lane B
//   rdata_a_i      bank read data, lane A
//   rdata_b_i      bank read data, lane B
//   out_valid_o    output beat valid
//   out_ready_i    downstream accepts the beat
//   out_data_a_o   lane A word
//   out_data_b_o   lane B word, zero when lane B is padding
//   out_keep_b_o   lane B holds a real word
//   out_last_o     final beat of the burst
//   state_o        current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module db_reader #(
   parameter int W     = 24,
   parameter int DEPTH = 40,
   parameter int ADDRW = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [ADDRW-1:0] base_addr_i,
   input  logic [ADDRW:0]   len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [ADDRW-1:0] raddr_a_o,
   output logic [ADDRW-1:0] raddr_b_o,
   input  logic [W-1:0]     rdata_a_i,
   input  logic [W-1:0]     rdata_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     out_data_a_o,
   output logic [W-1:0]     out_data_b_o,
   output logic             out_keep_b_o,
   output logic             out_last_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      WAIT_LAST = 2'd2,
      FIN       = 2'd3
   } state_t;

   localparam logic [ADDRW:0]   DEPTH_L = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW:0]   TWO_L   = (ADDRW+1)'(2);
   localparam logic [ADDRW-1:0] LAST_A  = ADDRW'(DEPTH-1);
   localparam logic [ADDRW-1:0] WRAP2_A = ADDRW'(DEPTH-2);

   state_t           state_q, state_d;
   logic [ADDRW-1:0] ptr_q, ptr_d;
   logic [ADDRW:0]   rem_q, rem_d;
   logic             err_flag_q, err_flag_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_a_q, out_data_a_d;
   logic [W-1:0]     out_data_b_q, out_data_b_d;
   logic             out_keep_b_q, out_keep_b_d;
   logic             out_last_q, out_last_d;

   logic             base_bad;
   logic             req_empty;
   logic [ADDRW:0]   len_clip;
   logic [ADDRW-1:0] ptr_adv;
   logic             rem_ge2;
   logic             rem_le2;
   logic             load;

   assign base_bad  = ({1'b0, base_addr_i} >= DEPTH_L);
   assign req_empty = (len_i == '0);
   assign len_clip  = (len_i > DEPTH_L) ? DEPTH_L : len_i;

   // ptr is always below DEPTH, so a single conditional subtract wraps it.
   // Doing it this way keeps the arithmetic inside ADDRW bits even when
   // DEPTH equals 2^ADDRW.
   assign ptr_adv = (ptr_q >= WRAP2_A) ? (ptr_q - WRAP2_A) : (ptr_q + ADDRW'(2));

   assign raddr_a_o = ptr_q;
   assign raddr_b_o = (ptr_q == LAST_A) ? '0 : (ptr_q + ADDRW'(1));

   assign rem_ge2 = (rem_q >= TWO_L);
   assign rem_le2 = (rem_q <= TWO_L);

   // A new beat may enter the output register when it is empty or when
   // its current beat leaves on this edge.
   assign load = (state_q == FETCH) && (!out_valid_q || out_ready_i);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      err_flag_d   = err_flag_q;
      out_valid_d  = out_valid_q;
      out_data_a_d = out_data_a_q;
      out_data_b_d = out_data_b_q;
      out_keep_b_d = out_keep_b_q;
      out_last_d   = out_last_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (base_bad || req_empty) begin
                  rem_d      = '0;
                  err_flag_d = base_bad;
                  state_d    = FIN;
               end else begin
                  ptr_d      = base_addr_i;
                  rem_d      = len_clip;
                  err_flag_d = 1'b0;
                  state_d    = FETCH;
               end
            end
         end
         FETCH: begin
            if (load) begin
               out_valid_d  = 1'b1;
               out_data_a_d = rdata_a_i;
               out_data_b_d = rem_ge2 ? rdata_b_i : '0;
               out_keep_b_d = rem_ge2;
               out_last_d   = rem_le2;
               ptr_d        = ptr_adv;
               rem_d        = rem_ge2 ? (rem_q - TWO_L) : '0;
               if (rem_le2) begin
                  state_d = WAIT_LAST;
               end
            end
         end
         WAIT_LAST: begin
            if (out_valid_q && out_ready_i) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         rem_q        <= '0;
         err_flag_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_a_q <= '0;
         out_data_b_q <= '0;
         out_keep_b_q <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         err_flag_q   <= err_flag_d;
         out_valid_q  <= out_valid_d;
         out_data_a_q <= out_data_a_d;
         out_data_b_q <= out_data_b_d;
         out_keep_b_q <= out_keep_b_d;
         out_last_q   <= out_last_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == FIN);
   assign err_o        = (state_q == FIN) && err_flag_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_a_o = out_data_a_q;
   assign out_data_b_o = out_data_b_q;
   assign out_keep_b_o = out_keep_b_q;
   assign out_last_o   = out_last_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_db_reader.sv
module tb_db_reader;

   localparam int W     = 24;
   localparam int DEPTH = 40;
   localparam int ADDRW = 6;

   logic             clk;
   logic             rst;
   logic             start;
   logic [ADDRW-1:0] base_addr;
   logic [ADDRW:0]   len;
   logic             busy;
   logic             done;
   logic             err;
   logic [ADDRW-1:0] raddr_a;
   logic [ADDRW-1:0] raddr_b;
   logic [W-1:0]     rdata_a;
   logic [W-1:0]     rdata_b;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data_a;
   logic [W-1:0]     out_data_b;
   logic             out_keep_b;
   logic             out_last;
   logic [1:0]       state_dbg;

   int checks;
   int errors;
   int beat_cnt;

   logic [W-1:0] mem [0:DEPTH-1];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank contents: mem[i] = i + 100, read asynchronously.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 100);
   end
   assign rdata_a = (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
   assign rdata_b = (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;

   db_reader #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .base_addr_i  (base_addr),
      .len_i        (len),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .raddr_a_o    (raddr_a),
      .raddr_b_o    (raddr_b),
      .rdata_a_i    (rdata_a),
      .rdata_b_i    (rdata_b),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_a_o (out_data_a),
      .out_data_b_o (out_data_b),
      .out_keep_b_o (out_keep_b),
      .out_last_o   (out_last),
      .state_o      (state_dbg)
   );

   // Accepted beats counted at the edge where the transfer happens.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) beat_cnt <= beat_cnt + 1;
   end

   // ---------------- checker / driver tasks ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Drive start for one edge, leaving the bench at the following negedge.
   task automatic pulse_start(input logic [ADDRW-1:0] b, input logic [ADDRW:0] l);
      base_addr = b;
      len       = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic check_beat(input string tag, input int a, input int b, input int keep, input int last);
      check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".a"},     32'(out_data_a), 32'(a));
      check_eq({tag, ".b"},     32'(out_data_b), 32'(b));
      check_eq({tag, ".keep"},  32'(out_keep_b), 32'(keep));
      check_eq({tag, ".last"},  32'(out_last), 32'(last));
   endtask

   task automatic check_done(input string tag, input int exp_err);
      check_eq({tag, ".done"},  32'(done), 32'd1);
      check_eq({tag, ".err"},   32'(err), 32'(exp_err));
      check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
      tick();
      check_eq({tag, ".done_clr"}, 32'(done), 32'd0);
      check_eq({tag, ".idle"},     32'(busy), 32'd0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      checks    = 0;
      errors    = 0;
      beat_cnt  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      out_ready = 1'b1;
      tick();
      tick();

      // Reset state
      check_eq("rst.valid", 32'(out_valid), 32'd0);
      check_eq("rst.busy",  32'(busy), 32'd0);
      check_eq("rst.done",  32'(done), 32'd0);
      check_eq("rst.err",   32'(err), 32'd0);
      check_eq("rst.keep",  32'(out_keep_b), 32'd0);
      check_eq("rst.last",  32'(out_last), 32'd0);
      check_eq("rst.da",    32'(out_data_a), 32'd0);
      check_eq("rst.db",    32'(out_data_b), 32'd0);
      check_eq("rst.ra",    32'(raddr_a), 32'd0);
      check_eq("rst.rb",    32'(raddr_b), 32'd1);

      // start together with rst is ignored
      start = 1'b1;
      base_addr = 6'd4;
      len = 7'd6;
      tick();
      start = 1'b0;
      check_eq("rststart.busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();
      check_eq("rststart.busy2", 32'(busy), 32'd0);

      // base=4 len=6, back-to-back beats
      beat_cnt = 0;
      out_ready = 1'b1;
      pulse_start(6'd4, 7'd6);
      check_eq("b1.busy",  32'(busy), 32'd1);
      check_eq("b1.nov",   32'(out_valid), 32'd0);
      tick(); check_beat("b1.beat0", 104, 105, 1, 0);
      tick(); check_beat("b1.beat1", 106, 107, 1, 0);
      tick(); check_beat("b1.beat2", 108, 109, 1, 1);
      tick(); check_done("b1", 0);
      check_eq("b1.beats", 32'(beat_cnt), 32'd3);

      // base=38 len=5, wraps past DEPTH-1
      beat_cnt = 0;
      pulse_start(6'd38, 7'd5);
      tick(); check_beat("b2.beat0", 138, 139, 1, 0);
      tick(); check_beat("b2.beat1", 100, 101, 1, 0);
      tick(); check_beat("b2.beat2", 102, 0, 0, 1);
      tick(); check_done("b2", 0);
      check_eq("b2.beats", 32'(beat_cnt), 32'd3);

      // base=0 len=4 with a 3-cycle stall on the first beat
      beat_cnt = 0;
      out_ready = 1'b0;
      pulse_start(6'd0, 7'd4);
      tick(); check_beat("b3.stall0", 100, 101, 1, 0);
      tick(); check_beat("b3.stall1", 100, 101, 1, 0);
      tick(); check_beat("b3.stall2", 100, 101, 1, 0);
      out_ready = 1'b1;
      tick(); check_beat("b3.beat1", 102, 103, 1, 1);
      tick(); check_done("b3", 0);
      check_eq("b3.beats", 32'(beat_cnt), 32'd2);

      // len=0: straight to FIN, no beats
      beat_cnt = 0;
      pulse_start(6'd3, 7'd0);
      check_done("len0", 0);
      check_eq("len0.beats", 32'(beat_cnt), 32'd0);

      // base out of range: done and err together, no beats
      beat_cnt = 0;
      pulse_start(6'd45, 7'd4);
      check_done("base45", 1);
      check_eq("base45.beats", 32'(beat_cnt), 32'd0);

      // len=63 clipped to DEPTH: 20 beats, mid-burst start ignored
      beat_cnt = 0;
      pulse_start(6'd0, 7'd63);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            start = 1'b1;
            base_addr = 6'd10;
            len = 7'd2;
         end
         tick();
         start = 1'b0;
         check_beat($sformatf("full.beat%0d", i), 100 + 2*i, 101 + 2*i, 1, (i == 19) ? 1 : 0);
      end
      tick(); check_done("full", 0);
      check_eq("full.beats", 32'(beat_cnt), 32'd20);

      // reset while a beat is pending and stalled
      out_ready = 1'b0;
      pulse_start(6'd10, 7'd6);
      tick(); check_beat("rstmid.pend", 110, 111, 1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstmid.valid", 32'(out_valid), 32'd0);
      check_eq("rstmid.busy",  32'(busy), 32'd0);
      check_eq("rstmid.da",    32'(out_data_a), 32'd0);
      check_eq("rstmid.keep",  32'(out_keep_b), 32'd0);
      out_ready = 1'b1;
      tick();
      check_eq("rstmid.still_idle", 32'(busy), 32'd0);
      beat_cnt = 0;
      pulse_start(6'd20, 7'd2);
      tick(); check_beat("after.beat0", 120, 121, 1, 1);
      tick(); check_done("after", 0);
      check_eq("after.beats", 32'(beat_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
